// File: rtl/regfile_scoreboard.sv
// Register scoreboard: one busy bit per writable register. It blocks issue on
// RAW/WAW hazards and provides a drain handshake and a saturating stall counter.
module regfile_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [5:0]  iss_ra,
    input  logic [5:0]  iss_rb,
    input  logic        iss_use_a,
    input  logic        iss_use_b,
    input  logic [5:0]  iss_rd,
    input  logic        iss_we,
    output logic        iss_ready,
    input  logic        wb_valid,
    input  logic [5:0]  wb_rd,
    input  logic        flush,
    input  logic        drain_req,
    output logic        drain_ack,
    output logic [5:0]  busy_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

    state_t      state, state_nxt;
    logic [61:0] busy, busy_nxt;
    logic [63:0] busy_ext, eff_busy, nxt_ext;
    logic        hazard;
    logic        run;
    logic [5:0]  cnt_nxt;

    // Registers 62/63 read as never busy, so index the padded vector directly.
    always_comb begin
        busy_ext = {2'b00, busy};
        eff_busy = busy_ext;
        if (wb_valid) eff_busy[wb_rd] = 1'b0;
    end

    always_comb begin
        hazard = (iss_use_a & eff_busy[iss_ra]) |
                 (iss_use_b & eff_busy[iss_rb]) |
                 (iss_we    & eff_busy[iss_rd]);
        iss_ready = rst_n & iss_valid & run & ~flush & ~hazard;
    end

    // Clear is applied before set so that a same-register set wins; flush overrides both.
    always_comb begin
        nxt_ext = busy_ext;
        if (wb_valid) nxt_ext[wb_rd] = 1'b0;
        if (iss_ready && iss_we) nxt_ext[iss_rd] = 1'b1;
        nxt_ext[63:62] = '0;
        if (flush) nxt_ext = '0;
        busy_nxt = nxt_ext[61:0];
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < 62; i++) begin
            cnt_nxt = cnt_nxt + 6'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= '0;
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (run && iss_valid && !iss_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (drain_req) state_nxt = DRAIN;
            DRAIN:   if (busy_nxt == '0) state_nxt = ACK;
            ACK:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        run       = (state == RUN);
        drain_ack = (state == ACK);
    end

endmodule
